// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the square-root significand path.
// Holds the issue payload (operand significand + exponent LSB), the requester
// tag type carried alongside each op, and the datapath latency helper.
package fp_sqrt_pkg;

  // Widest significand and tag the shared types can carry (binary32, 16 requesters).
  localparam int unsigned SIG_W_MAX = 23;
  localparam int unsigned TAG_W_MAX = 4;

  typedef logic [TAG_W_MAX-1:0] req_tag_t;

  typedef struct packed {
    logic [SIG_W_MAX-1:0] sig;
    logic                 exp_lsb;
  } sqrt_op_t;

  // Datapath latency in cycles: one per pipeline register.
  function automatic int unsigned sqrt_lat(input int unsigned pipe_stages);
    return pipe_stages;
  endfunction

endpackage

// File: rtl/sqrt_sigcalc.sv
// Significand square root datapath.
// Computes q = floor(sqrt(1.sig * 2^exp_lsb) * 2^(SIG_W+1)) and the sticky bit
// (non-zero remainder), then retimes the result through PIPE_STAGES registers.
// Ports:
//   clk, resetn      clock, async active-low reset
//   en               pipeline advance enable
//   a_sig, a_exp_lsb operand significand (no hidden bit) and exponent LSB
//   z_sig_nr         {q, sticky}: hidden + SIG_W fraction + guard + sticky, unrounded
module sqrt_sigcalc #(
  parameter int unsigned SIG_W       = 23,
  parameter int unsigned PIPE_STAGES = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [SIG_W-1:0] a_sig,
  input  logic             a_exp_lsb,
  output logic [SIG_W+2:0] z_sig_nr
);

  localparam int unsigned Q_W   = SIG_W + 2;
  localparam int unsigned RAD_W = 2 * Q_W;
  localparam int unsigned REM_W = Q_W + 2;
  localparam int unsigned Z_W   = SIG_W + 3;

  logic [RAD_W-1:0] rad;
  logic [Q_W-1:0]   root;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] trial;
  logic [Z_W-1:0]   z_c;

  // Restoring digit-by-digit square root, one result bit per radicand bit pair.
  always_comb begin
    rad   = RAD_W'({1'b1, a_sig}) << (SIG_W + 2);
    if (a_exp_lsb) begin
      rad = rad << 1;
    end
    rem   = '0;
    root  = '0;
    trial = '0;
    for (int i = Q_W - 1; i >= 0; i--) begin
      rem   = {rem[REM_W-3:0], rad[2*i +: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[Q_W-2:0], 1'b1};
      end else begin
        root = {root[Q_W-2:0], 1'b0};
      end
    end
    z_c = {root, |rem};
  end

  generate
    if (PIPE_STAGES == 0) begin : g_comb
      assign z_sig_nr = z_c;
    end else begin : g_pipe
      logic [PIPE_STAGES-1:0][Z_W-1:0] pipe_q;
      logic [PIPE_STAGES-1:0][Z_W-1:0] pipe_d;

      // Output retiming registers.
      always_comb begin
        pipe_d = pipe_q;
        if (en) begin
          pipe_d[0] = z_c;
          for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            pipe_d[s] = pipe_q[s-1];
          end
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign z_sig_nr = pipe_q[PIPE_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sqrt_sig_sched.sv
// Shares one sqrt_sigcalc datapath between NUM_REQ requesters.
// Round-robin issue, one outstanding op per requester, a valid/tag shift register
// that follows each op through the datapath, and a per-requester result buffer.
// Ports:
//   clk, resetn                  clock, async active-low reset
//   req_valid/req_ready          operand handshake; req_ready is the one-hot grant
//   req_sig/req_exp_lsb          operand significand and exponent LSB per requester
//   rsp_valid/rsp_ready/rsp_sig  result buffer handshake and {q, sticky} payload
//   busy                         any op in flight or any result buffered
module sqrt_sig_sched
  import fp_sqrt_pkg::*;
#(
  parameter int unsigned SIG_W       = 23,
  parameter int unsigned PIPE_STAGES = 0,
  parameter int unsigned NUM_REQ     = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][SIG_W-1:0]   req_sig,
  input  logic [NUM_REQ-1:0]              req_exp_lsb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [NUM_REQ-1:0][SIG_W+2:0]   rsp_sig,
  output logic                            busy
);

  localparam int unsigned LAT   = sqrt_lat(PIPE_STAGES);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned Z_W   = SIG_W + 3;

  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][Z_W-1:0]   rsp_sig_q, rsp_sig_d;

  logic [NUM_REQ-1:0] inflight;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_c;
  logic [NUM_REQ-1:0] cap_mask;
  logic [NUM_REQ-1:0] pop_mask;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  int unsigned        best_off;
  int unsigned        off;
  sqrt_op_t           issue_op;
  logic               cap_vld;
  req_tag_t           cap_tag;
  logic [Z_W-1:0]     z_sig_nr;

  // Round-robin arbiter: closest eligible requester at or after ptr wins.
  always_comb begin
    pend        = inflight | rsp_valid_q;
    eligible    = req_valid & ~pend;
    grant_found = 1'b0;
    grant_idx   = '0;
    best_off    = NUM_REQ;
    off         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - 32'(ptr_q)) % NUM_REQ;
      if (eligible[i] && (off < best_off)) begin
        best_off    = off;
        grant_idx   = PTR_W'(i);
        grant_found = 1'b1;
      end
    end
    grant_c = '0;
    if (grant_found) begin
      grant_c[grant_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (grant_found) begin
      if (32'(grant_idx) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + PTR_W'(1);
      end
    end
  end

  // Grant is held off while reset is asserted so no handshake completes then.
  assign req_ready = resetn ? grant_c : '0;

  // Issue mux onto the shared datapath.
  always_comb begin
    issue_op.sig     = SIG_W_MAX'(req_sig[grant_idx]);
    issue_op.exp_lsb = req_exp_lsb[grant_idx];
  end

  sqrt_sigcalc #(
    .SIG_W       (SIG_W),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_sigcalc (
    .clk       (clk),
    .resetn    (resetn),
    .en        (1'b1),
    .a_sig     (SIG_W'(issue_op.sig)),
    .a_exp_lsb (issue_op.exp_lsb),
    .z_sig_nr  (z_sig_nr)
  );

  // Valid/tag tracker aligned with the datapath; a zero-latency datapath captures directly.
  generate
    if (LAT == 0) begin : g_notrack
      assign cap_vld  = grant_found;
      assign cap_tag  = req_tag_t'(grant_idx);
      assign inflight = '0;
    end else begin : g_track
      logic [LAT-1:0]     vld_q, vld_d;
      req_tag_t [LAT-1:0] tag_q, tag_d;

      always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        vld_d[0] = grant_found;
        tag_d[0] = req_tag_t'(grant_idx);
        for (int unsigned s = 1; s < LAT; s++) begin
          vld_d[s] = vld_q[s-1];
          tag_d[s] = tag_q[s-1];
        end
      end

      // Requesters with an op anywhere in the datapath.
      always_comb begin
        inflight = '0;
        for (int unsigned s = 0; s < LAT; s++) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (vld_q[s] && (tag_q[s] == req_tag_t'(i))) begin
              inflight[i] = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          vld_q <= '0;
          tag_q <= '0;
        end else begin
          vld_q <= vld_d;
          tag_q <= tag_d;
        end
      end

      assign cap_vld = vld_q[LAT-1];
      assign cap_tag = tag_q[LAT-1];
    end
  endgenerate

  // Result buffers: capture completing op into its owner's slot, clear on pop.
  always_comb begin
    rsp_sig_d = rsp_sig_q;
    cap_mask  = '0;
    pop_mask  = rsp_valid_q & rsp_ready;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cap_vld && (cap_tag == req_tag_t'(i))) begin
        cap_mask[i]  = 1'b1;
        rsp_sig_d[i] = z_sig_nr;
      end
    end
    rsp_valid_d = (rsp_valid_q & ~pop_mask) | cap_mask;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sig_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sig_q   <= rsp_sig_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sig   = rsp_sig_q;
  assign busy      = (|inflight) | (|rsp_valid_q);

  // A slot being filled can never be popped in the same cycle.
  assert property (@(posedge clk) disable iff (!resetn) ((cap_mask & pop_mask) == '0));

endmodule

// File: tb/tb_sqrt_sig_sched.sv
// Bench for sqrt_sig_sched: directed table, random traffic against a
// transaction-level model, and hand sequences for backpressure, wrap, idle, reset.
module tb_sqrt_sig_sched;

  parameter int PIPE_STAGES = 2;
  localparam int SIG_W   = 23;
  localparam int NUM_REQ = 4;
  localparam int Z_W     = SIG_W + 3;
  localparam int LAT     = PIPE_STAGES;

  logic clk;
  logic resetn;
  logic [NUM_REQ-1:0]            req_valid, req_ready, req_exp_lsb;
  logic [NUM_REQ-1:0]            rsp_valid, rsp_ready;
  logic [NUM_REQ-1:0][SIG_W-1:0] req_sig;
  logic [NUM_REQ-1:0][Z_W-1:0]   rsp_sig;
  logic                          busy;

  sqrt_sig_sched #(
    .SIG_W       (SIG_W),
    .PIPE_STAGES (PIPE_STAGES),
    .NUM_REQ     (NUM_REQ)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sig     (req_sig),
    .req_exp_lsb (req_exp_lsb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_sig     (rsp_sig),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;

  // Transaction model: an op is pending from accept until its result is popped.
  bit             m_pend [NUM_REQ];
  int             m_acc  [NUM_REQ];
  logic [Z_W-1:0] m_res  [NUM_REQ];
  int             m_ptr;
  int             cyc;

  logic [NUM_REQ-1:0]          s_ready, s_rv;
  logic [NUM_REQ-1:0][Z_W-1:0] s_sig;
  int                          s_cyc;
  int                          grants[$];

  typedef struct {
    logic [SIG_W-1:0] sig;
    logic             e;
    logic [Z_W-1:0]   exp_z;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden sqrt: integer square root of the scaled radicand, sticky = inexact.
  function automatic logic [Z_W-1:0] golden(input logic [SIG_W-1:0] sig, input logic e);
    longint unsigned x, q;
    real r;
    x = ((64'd1 << SIG_W) | 64'(sig)) << (SIG_W + 2 + int'(e));
    r = real'(x);
    q = 64'($rtoi($sqrt(r)));
    while (q * q > x) q--;
    while ((q + 1) * (q + 1) <= x) q++;
    return {q[SIG_W+1:0], (q * q != x)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) m_pend[i] = 1'b0;
    m_ptr = 0;
  endtask

  // One cycle: inputs already driven; sample, compare with model, advance model and clock.
  task automatic step();
    logic [NUM_REQ-1:0] e_ready, e_rv;
    int  g;
    bit  anyp;
    #1;
    s_ready = req_ready;
    s_rv    = rsp_valid;
    s_sig   = rsp_sig;
    s_cyc   = cyc;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[i] && !m_pend[i]) g = i;
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    anyp = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      e_rv[i] = m_pend[i] && (cyc >= m_acc[i] + LAT + 1);
      anyp |= m_pend[i];
    end
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (e_rv[i]) chk($sformatf("rsp_sig[%0d]", i), 64'(rsp_sig[i]), 64'(m_res[i]));
    end
    chk("busy", 64'(busy), 64'(anyp));
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grants.push_back(i);
    if (g >= 0) begin
      m_pend[g] = 1'b1;
      m_acc[g]  = cyc;
      m_res[g]  = golden(req_sig[g], req_exp_lsb[g]);
      m_ptr     = (g + 1) % NUM_REQ;
    end
    for (int i = 0; i < NUM_REQ; i++) if (e_rv[i] && rsp_ready[i]) m_pend[i] = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_sig[i]     = SIG_W'($urandom);
      req_exp_lsb[i] = 1'($urandom);
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (LAT + 4) step();
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int saved_ptr;
    int others;
    logic [Z_W-1:0] held;
    bit got;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    model_reset();

    vecs[0] = '{sig: 23'h000000, e: 1'b0, exp_z: 26'h2000000};
    vecs[1] = '{sig: 23'h000000, e: 1'b1, exp_z: 26'h2D413CD};
    vecs[2] = '{sig: 23'h100000, e: 1'b1, exp_z: 26'h3000000};
    vecs[3] = '{sig: 23'h480000, e: 1'b0, exp_z: 26'h2800000};
    vecs[4] = '{sig: 23'h220000, e: 1'b0, exp_z: 26'h2400000};
    vecs[5] = '{sig: 23'h440000, e: 1'b1, exp_z: 26'h3800000};

    resetn      = 1'b0;
    req_valid   = '0;
    rsp_ready   = '0;
    req_sig     = '0;
    req_exp_lsb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset rsp_sig", 64'(rsp_sig), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    req_valid = '0;
    resetn    = 1'b1;
    @(negedge clk);

    // Directed vectors: value and LAT+1 response latency.
    for (int k = 0; k < 6; k++) begin
      int r, acc_c;
      r = k % NUM_REQ;
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_sig[r] = vecs[k].sig;
      req_exp_lsb[r] = vecs[k].e;
      rsp_ready = '0;
      got = 1'b0;
      acc_c = 0;
      for (int w = 0; w < 10 && !got; w++) begin
        step();
        if (s_ready[r]) begin got = 1'b1; acc_c = s_cyc; end
      end
      chk("vec accept", 64'(got), 64'h1);
      req_valid = '0;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        step();
        if (s_rv[r]) begin
          got = 1'b1;
          chk($sformatf("vec%0d latency", k), 64'(s_cyc - acc_c), 64'(LAT + 1));
          chk($sformatf("vec%0d rsp_sig", k), 64'(s_sig[r]), 64'(vecs[k].exp_z));
        end
      end
      chk("vec rsp arrives", 64'(got), 64'h1);
      rsp_ready[r] = 1'b1;
      step();
      rsp_ready = '0;
    end

    // All requesters valid, results consumed: strict rotation.
    saved_ptr = m_ptr;
    grants.delete();
    req_valid = '1;
    rsp_ready = '1;
    repeat (40) begin
      randomize_ops();
      step();
    end
    chk("rotation count", 64'(grants.size() >= 12), 64'h1);
    for (int k = 0; k < 12 && k < grants.size(); k++) begin
      chk($sformatf("rotation grant %0d", k), 64'(grants[k]), 64'((saved_ptr + k) % NUM_REQ));
    end
    drain();

    // Backpressure on requester 2.
    req_valid = '1;
    rsp_ready = 4'b1011;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      randomize_ops();
      step();
      if (s_rv[2]) got = 1'b1;
    end
    chk("bp rsp2 arrives", 64'(got), 64'h1);
    held = s_sig[2];
    grants.delete();
    repeat (20) begin
      randomize_ops();
      step();
      chk("bp req_ready[2]", 64'(s_ready[2]), 64'h0);
      chk("bp rsp_sig[2] stable", 64'(s_sig[2]), 64'(held));
    end
    others = grants.size();
    chk("bp others issue", 64'(others > 4), 64'h1);
    rsp_ready = '1;
    grants.delete();
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      randomize_ops();
      step();
      if (s_ready[2]) got = 1'b1;
    end
    chk("bp req2 reaccepted", 64'(got), 64'h1);
    drain();

    // Wrap: put ptr at 3, then only requesters 3 and 0 compete.
    req_valid = 4'b0100;
    step();
    drain();
    grants.delete();
    req_valid = 4'b1001;
    repeat (12) begin
      randomize_ops();
      step();
    end
    chk("wrap count", 64'(grants.size() >= 3), 64'h1);
    if (grants.size() >= 3) begin
      chk("wrap grant0", 64'(grants[0]), 64'd3);
      chk("wrap grant1", 64'(grants[1]), 64'd0);
      chk("wrap grant2", 64'(grants[2]), 64'd3);
    end
    drain();

    // Idle: nothing requested, pointer must hold.
    saved_ptr = m_ptr;
    req_valid = '0;
    repeat (10) begin
      step();
      chk("idle busy", 64'(busy), 64'h0);
    end
    req_valid = '1;
    step();
    chk("idle ptr held", 64'(s_ready), 64'(1 << saved_ptr));
    drain();

    // Reset with ops in flight and results buffered.
    req_valid = '1;
    rsp_ready = '0;
    repeat (4) begin
      randomize_ops();
      step();
    end
    chk("pre-reset busy", 64'(busy), 64'h1);
    resetn = 1'b0;
    #1;
    chk("midreset req_ready", 64'(req_ready), 64'h0);
    chk("midreset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("midreset rsp_sig", 64'(rsp_sig), 64'h0);
    chk("midreset busy", 64'(busy), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    req_valid = '0;
    resetn    = 1'b1;
    rsp_ready = '1;
    repeat (LAT + 10) begin
      step();
      chk("no stale rsp", 64'(s_rv), 64'h0);
    end

    // Random traffic against the model.
    repeat (300) begin
      req_valid = NUM_REQ'($urandom);
      rsp_ready = NUM_REQ'($urandom);
      randomize_ops();
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
